mux_4x1_32bit: RTL and testbench

- 4-to-1 multiplexer for 32-bit data words, used in the datapath for operand, result and writeback selection.
- Primary output Y is purely combinational from s and I0..I3.
- A registered copy of the selected word, Y_q, is also provided. It is captured on clk under enable and cleared by an asynchronous active-low reset, for pipelined users.

---
 rtl/mux_4x1_32bit.sv | 58 +++++
 tb/tb_mux_4x1_32bit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux_4x1_32bit.sv
// ---------------------------------------------------------------------------
// mux_4x1_32bit
//   4-to-1 word multiplexer for the datapath (operand / result / writeback
//   select). Y is purely combinational. Y_q / s_q are a registered copy of
//   the selected word and its select, for pipelined consumers.
//
// Ports (declaration order is fixed for positional instantiation):
//   Y      out WIDTH  combinational selected word
//   s      in  2      select: 00->I0, 01->I1, 10->I2, 11->I3
//   I3..I0 in  WIDTH  data inputs
//   clk    in  1      rising edge captures Y/s into Y_q/s_q when en=1
//   rst_n  in  1      async active-low clear of Y_q/s_q only
//   en     in  1      capture enable
//   Y_q    out WIDTH  registered selected word
//   s_q    out 2      registered select
// ---------------------------------------------------------------------------
module mux_4x1_32bit #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] Y,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] I3,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I0,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] Y_q,
  output logic [1:0]       s_q
);

  // Combinational select. An X/Z select bit matches no item, so the default
  // drives zero rather than propagating an arbitrary input.
  always_comb begin
    Y = '0;
    case (s)
      2'b00:   Y = I0;
      2'b01:   Y = I1;
      2'b10:   Y = I2;
      2'b11:   Y = I3;
      default: Y = '0;
    endcase
  end

  // Registered copy. Reset release is expected to be synchronous to clk
  // already; no synchroniser here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y_q <= '0;
      s_q <= 2'b00;
    end else if (en) begin
      Y_q <= Y;
      s_q <= s;
    end
  end

endmodule

// File: tb/tb_mux_4x1_32bit.sv
// ---------------------------------------------------------------------------
// tb_mux_4x1_32bit
//   Table-driven checks of the combinational select, walking-ones sweep,
//   hand-written reset/enable sequences and a randomised registered-path run
//   whose expected Y_q/s_q values go through a queue scoreboard.
// ---------------------------------------------------------------------------
module tb_mux_4x1_32bit;

  localparam int W = 32;

  logic [W-1:0] Y, Y_q;
  logic [1:0]   s, s_q;
  logic [W-1:0] I0, I1, I2, I3;
  logic         clk, rst_n, en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [1:0] s;
    logic [W-1:0] i0, i1, i2, i3;
    logic [W-1:0] y;
  } vec_t;

  typedef struct {
    logic [W-1:0] y_q;
    logic [1:0]   s_q;
  } exp_t;

  exp_t sb[$];

  mux_4x1_32bit #(.WIDTH(W)) dut (
    .Y(Y), .s(s), .I3(I3), .I2(I2), .I1(I1), .I0(I0),
    .clk(clk), .rst_n(rst_n), .en(en), .Y_q(Y_q), .s_q(s_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mux(input logic [1:0] sel,
      input logic [W-1:0] a0, a1, a2, a3);
    case (sel)
      2'b00:   return a0;
      2'b01:   return a1;
      2'b10:   return a2;
      2'b11:   return a3;
      default: return '0;
    endcase
  endfunction

  // Pop one scoreboard entry after a rising edge and compare it.
  task automatic sb_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_yq"}, Y_q, e.y_q);
      chk({name, "_sq"}, {30'd0, s_q}, {30'd0, e.s_q});
    end
  endtask

  initial begin
    vec_t tbl[10];
    logic [W-1:0] cur_yq;
    logic [1:0]   cur_sq;
    logic [W-1:0] one;

    tbl[0] = '{"sweep_s0", 2'b00, 32'h00000000, 32'h00001111, 32'h11110000, 32'h11111111, 32'h00000000};
    tbl[1] = '{"sweep_s1", 2'b01, 32'h00000000, 32'h00001111, 32'h11110000, 32'h11111111, 32'h00001111};
    tbl[2] = '{"sweep_s2", 2'b10, 32'h00000000, 32'h00001111, 32'h11110000, 32'h11111111, 32'h11110000};
    tbl[3] = '{"sweep_s3", 2'b11, 32'h00000000, 32'h00001111, 32'h11110000, 32'h11111111, 32'h11111111};
    tbl[4] = '{"track_a5", 2'b10, 32'h00000000, 32'h00001111, 32'hA5A5A5A5, 32'h11111111, 32'hA5A5A5A5};
    tbl[5] = '{"track_5a", 2'b10, 32'h00000000, 32'h00001111, 32'h5A5A5A5A, 32'h11111111, 32'h5A5A5A5A};
    tbl[6] = '{"track_i0", 2'b10, 32'hFFFFFFFF, 32'h00001111, 32'h5A5A5A5A, 32'h11111111, 32'h5A5A5A5A};
    tbl[7] = '{"track_i1", 2'b10, 32'hFFFFFFFF, 32'h12345678, 32'h5A5A5A5A, 32'h11111111, 32'h5A5A5A5A};
    tbl[8] = '{"track_i3", 2'b10, 32'hFFFFFFFF, 32'h12345678, 32'h5A5A5A5A, 32'h87654321, 32'h5A5A5A5A};
    // X select: I2/I3 zero so a 2-state simulator resolving the X either way
    // still must produce zero; I0/I1 non-zero catch a wrong high bit.
    tbl[9] = '{"x_select", 2'b1x, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000};

    // Reset state
    rst_n = 1'b0; en = 1'b0; s = 2'b00;
    I0 = '0; I1 = '0; I2 = '0; I3 = '0;
    #2;
    chk("rst_yq", Y_q, '0);
    chk("rst_sq", {30'd0, s_q}, '0);

    // Combinational table, en idle
    foreach (tbl[k]) begin
      s = tbl[k].s; I0 = tbl[k].i0; I1 = tbl[k].i1; I2 = tbl[k].i2; I3 = tbl[k].i3;
      #0; #0;
      chk(tbl[k].name, Y, tbl[k].y);
      #10;
    end

    // Walking ones; non-selected inputs carry the complement so any wrong
    // select or lane leak shows up.
    for (int sel = 0; sel < 4; sel++) begin
      for (int b = 0; b < W; b++) begin
        one = '0; one[b] = 1'b1;
        s  = sel[1:0];
        I0 = (sel == 0) ? one : ~one;
        I1 = (sel == 1) ? one : ~one;
        I2 = (sel == 2) ? one : ~one;
        I3 = (sel == 3) ? one : ~one;
        #1;
        chk($sformatf("walk_s%0d_b%0d", sel, b), Y, one);
      end
    end

    // Release reset away from the edge
    @(negedge clk);
    rst_n = 1'b1;
    cur_yq = '0; cur_sq = 2'b00;

    // Capture with en=1
    en = 1'b1; s = 2'b01; I1 = 32'hDEADBEEF;
    cur_yq = 32'hDEADBEEF; cur_sq = 2'b01;
    sb.push_back('{cur_yq, cur_sq});
    @(posedge clk); #1;
    sb_check("capture");

    // Hold with en=0 for two edges
    @(negedge clk);
    en = 1'b0; s = 2'b11; I3 = 32'hCAFEF00D;
    sb.push_back('{cur_yq, cur_sq});
    sb.push_back('{cur_yq, cur_sq});
    @(posedge clk); #1;
    sb_check("hold1");
    @(posedge clk); #1;
    sb_check("hold2");
    chk("hold_y", Y, 32'hCAFEF00D);

    // Randomised registered path through the scoreboard
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      en = 1'($urandom_range(0, 1));
      s  = 2'($urandom_range(0, 3));
      I0 = $urandom; I1 = $urandom; I2 = $urandom; I3 = $urandom;
      if (en) begin
        cur_yq = ref_mux(s, I0, I1, I2, I3);
        cur_sq = s;
      end
      sb.push_back('{cur_yq, cur_sq});
      @(posedge clk); #1;
      sb_check($sformatf("rand%0d", n));
    end

    // Ensure Y_q is non-zero, then reset between edges
    @(negedge clk);
    en = 1'b1; s = 2'b10; I2 = 32'h13579BDF;
    @(posedge clk); #1;
    chk("pre_rst_yq", Y_q, 32'h13579BDF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_yq", Y_q, '0);
    chk("midrst_sq", {30'd0, s_q}, '0);
    chk("midrst_y", Y, 32'h13579BDF);
    // Clock edges while held in reset keep the registers clear
    @(posedge clk); #1;
    chk("inrst_yq", Y_q, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_yq", Y_q, 32'h13579BDF);
    chk("post_rst_sq", {30'd0, s_q}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
